grid_mem: RTL

- Board-state store that sits directly upstream of draw_ships.
- Holds a GRID_SIZE x GRID_SIZE array of 2-bit cell codes.
- Answers the drawer's grid_addr with a registered grid_status, and executes place/shoot/clear commands from game logic over a valid/ready handshake.
- Tracks remaining ship cells and flags when all ships are sunk.

---
 rtl/grid_mem.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/grid_mem.sv
// Board-state store: GRID_SIZE x GRID_SIZE 2-bit cells, registered drawer read port,
// place/shoot/clear command FSM. Define GRID_MEM_HIDE_SHIPS_EN to mask unhit ships on the read port.
module grid_mem #(
  parameter int GRID_SIZE = 10,
  parameter int MAX_SHIPS = 20,
  localparam int SL_W = $clog2(MAX_SHIPS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      grid_addr,
  output logic [1:0]      grid_status,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [7:0]      cmd_addr,
  output logic            rsp_valid,
  output logic [1:0]      rsp_code,
  output logic [SL_W-1:0] ships_left,
  output logic            all_sunk
);

  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W     = $clog2(NUM_CELLS);

  localparam logic [7:0]       GS8       = 8'(GRID_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CELLS - 1);
  localparam logic [SL_W-1:0]  SHIPS_MAX = SL_W'(MAX_SHIPS);

  localparam logic [1:0] OP_PLACE = 2'b00;
  localparam logic [1:0] OP_SHOOT = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_HIT      = 2'b01;
  localparam logic [1:0] RSP_REJECTED = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR,
    ST_RESP
  } state_t;

  function automatic logic addr_in_range(input logic [7:0] a);
    return ({4'b0000, a[7:4]} < GS8) && ({4'b0000, a[3:0]} < GS8);
  endfunction

  function automatic logic [IDX_W-1:0] addr_to_index(input logic [7:0] a);
    logic [7:0] lin;
    lin = 8'({4'b0000, a[7:4]} * GS8) + {4'b0000, a[3:0]};
    return IDX_W'(lin);
  endfunction

  state_t           state_reg;
  logic             cmd_ready_reg;
  logic             rsp_valid_reg;
  logic [1:0]       rsp_code_reg;
  logic [1:0]       op_reg;
  logic [7:0]       addr_reg;
  logic [IDX_W-1:0] clr_idx_reg;
  logic [SL_W-1:0]  ships_left_reg;
  logic             placed_reg;
  logic             all_sunk_reg;
  logic [1:0]       grid_status_reg;

  logic [1:0]       cell_reg [NUM_CELLS];

  // Cell storage: one write port shared by EXEC and CLEAR, async reset empties the board.
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cell_reg[gi] <= CELL_EMPTY;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          cell_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Drawer read port, independent of the FSM.
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_cell;
  logic [1:0]       grid_status_next;

  always_comb begin
    rd_idx  = addr_to_index(grid_addr);
    rd_cell = CELL_EMPTY;
    if (addr_in_range(grid_addr)) begin
      rd_cell = cell_reg[rd_idx];
    end
`ifdef GRID_MEM_HIDE_SHIPS_EN
    grid_status_next = (rd_cell == CELL_SHIP) ? CELL_EMPTY : rd_cell;
`else
    grid_status_next = rd_cell;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grid_status_reg <= CELL_EMPTY;
    end else begin
      grid_status_reg <= grid_status_next;
    end
  end

  // Read-modify-write decision for the captured command.
  logic [IDX_W-1:0] exec_idx;
  logic [1:0]       exec_cell;
  logic             exec_write;
  logic [1:0]       exec_data;
  logic [1:0]       exec_code;
  logic [SL_W-1:0]  ships_left_next;
  logic             placed_next;
  logic             all_sunk_next;

  always_comb begin
    exec_idx        = addr_to_index(addr_reg);
    exec_cell       = CELL_EMPTY;
    exec_write      = 1'b0;
    exec_data       = CELL_EMPTY;
    exec_code       = RSP_REJECTED;
    ships_left_next = ships_left_reg;
    placed_next     = placed_reg;
    if (addr_in_range(addr_reg)) begin
      exec_cell = cell_reg[exec_idx];
      if (op_reg == OP_PLACE) begin
        if ((exec_cell == CELL_EMPTY) && (ships_left_reg != SHIPS_MAX)) begin
          exec_write      = 1'b1;
          exec_data       = CELL_SHIP;
          exec_code       = RSP_OK;
          ships_left_next = ships_left_reg + SL_W'(1);
          placed_next     = 1'b1;
        end
      end else if (op_reg == OP_SHOOT) begin
        if (exec_cell == CELL_SHIP) begin
          exec_write      = 1'b1;
          exec_data       = CELL_HIT;
          exec_code       = RSP_HIT;
          ships_left_next = ships_left_reg - SL_W'(1);
        end else if (exec_cell == CELL_EMPTY) begin
          exec_write = 1'b1;
          exec_data  = CELL_MISS;
          exec_code  = RSP_OK;
        end
      end
    end
    all_sunk_next = (ships_left_next == '0) && placed_next;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = exec_idx;
    wr_data = exec_data;
    if (state_reg == ST_EXEC) begin
      wr_en = exec_write;
    end else if (state_reg == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx_reg;
      wr_data = CELL_EMPTY;
    end
  end

  // Command FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cmd_ready_reg  <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_code_reg   <= RSP_OK;
      op_reg         <= OP_PLACE;
      addr_reg       <= 8'h00;
      clr_idx_reg    <= '0;
      ships_left_reg <= '0;
      placed_reg     <= 1'b0;
      all_sunk_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_reg) begin
            op_reg        <= cmd_op;
            addr_reg      <= cmd_addr;
            cmd_ready_reg <= 1'b0;
            if ((cmd_op == OP_PLACE) || (cmd_op == OP_SHOOT)) begin
              state_reg <= ST_EXEC;
            end else if (cmd_op == OP_CLEAR) begin
              clr_idx_reg <= '0;
              state_reg   <= ST_CLEAR;
            end else begin
              rsp_valid_reg <= 1'b1;
              rsp_code_reg  <= RSP_REJECTED;
              state_reg     <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          rsp_valid_reg  <= 1'b1;
          rsp_code_reg   <= exec_code;
          ships_left_reg <= ships_left_next;
          placed_reg     <= placed_next;
          all_sunk_reg   <= all_sunk_next;
          state_reg      <= ST_RESP;
        end
        ST_CLEAR: begin
          clr_idx_reg <= clr_idx_reg + IDX_W'(1);
          if (clr_idx_reg == LAST_IDX) begin
            ships_left_reg <= '0;
            placed_reg     <= 1'b0;
            all_sunk_reg   <= 1'b0;
            rsp_valid_reg  <= 1'b1;
            rsp_code_reg   <= RSP_OK;
            state_reg      <= ST_RESP;
          end
        end
        ST_RESP: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign grid_status = grid_status_reg;
  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_code    = rsp_code_reg;
  assign ships_left  = ships_left_reg;
  assign all_sunk    = all_sunk_reg;

endmodule
